packed_mac_pe: RTL and testbench

//  Parametrised successor to the dual-product DSP PE. One multiplier computes LANES products
//  A*B[k] at once, packing the B operand magnitudes at 2*IN_W-bit spacing. Each lane's sign is

---
 rtl/pe_pkg.sv | 51 +++++
 rtl/pe_lane_acc.sv | 102 ++++++++++
 rtl/packed_mac_pe.sv | 171 +++++++++++++++++
 tb/tb_packed_mac_pe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Package for the packed multiply-accumulate PE.
// Holds the lane-spacing and product-width helpers and the saturation
// functions shared by the per-lane accumulators.
package pe_pkg;

  // Wide enough to hold any accumulator sum before clamping (ACC_W + 2 <= 64).
  localparam int SAT_MAX_W = 64;

  // Default build: IN_W=8, LANES=2.
  localparam int IN_W_DEF  = 8;
  localparam int LANES_DEF = 2;
  localparam int PROD_W    = IN_W_DEF + LANES_DEF * 2 * IN_W_DEF;

  typedef logic signed [SAT_MAX_W-1:0] wide_t;

  // Bit spacing between packed B lanes. Each lane product |A|*|B[k]| is
  // strictly below 2^(2*IN_W), so lanes never carry into each other.
  function automatic int lane_sp(input int in_w);
    return 2 * in_w;
  endfunction

  // Full width of the packed product for a given build.
  function automatic int prod_w(input int in_w, input int lanes);
    return in_w + lanes * 2 * in_w;
  endfunction

  // Clamp x into the two's complement range of a w-bit value.
  function automatic wide_t sat_signed(input wide_t x, input int w);
    wide_t one;
    wide_t hi;
    wide_t lo;
    one = wide_t'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Clamp x into the unsigned range of a w-bit value.
  function automatic wide_t sat_unsigned(input wide_t x, input int w);
    wide_t one;
    wide_t hi;
    one = wide_t'(1);
    hi  = (one <<< w) - one;
    if (x > hi) return hi;
    if (x < 0) return '0;
    return x;
  endfunction

endpackage

// File: rtl/pe_lane_acc.sv
// One accumulation lane of the packed MAC PE.
// Registers the sign-restored lane product (pipeline stage S2), then adds it
// into a saturating accumulator with a sticky saturation flag. On the last
// beat of a sum the clamped total goes to the result register and the
// accumulator restarts from zero in the same cycle.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   advance         pipeline may move (not stalled)
//   flush           discard partial sum and the beat held in S2
//   in_valid        S1 holds a beat
//   in_mag          unsigned lane product magnitude from S1 (2*IN_W bits)
//   in_sign         restore a negative sign on this lane
//   in_mode         1: signed sum, 0: unsigned sum
//   in_last         beat closes the sum
//   out_acc         result of the last completed sum
//   out_sat         sum saturated at some point
module pe_lane_acc
  import pe_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int ACC_W = 2 * IN_W + 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [2*IN_W-1:0]  in_mag,
  input  logic               in_sign,
  input  logic               in_mode,
  input  logic               in_last,
  output logic [ACC_W-1:0]   out_acc,
  output logic               out_sat
);

  // Two guard bits: one for the sign of the lane value, one for the carry
  // of acc + value in either mode.
  localparam int SW = ACC_W + 2;

  logic        [SW-1:0]    mag_ext;
  logic signed [SW-1:0]    val_c;

  logic                    v2;
  logic                    last2;
  logic                    mode2;
  logic signed [SW-1:0]    val2;
  logic        [ACC_W-1:0] acc;
  logic                    sticky;

  logic signed [SW-1:0]    acc_ext;
  logic signed [SW-1:0]    sum;
  wide_t                   wide;
  wide_t                   clamped;
  logic                    sat_hit;
  logic        [ACC_W-1:0] res;

  assign mag_ext = {{(SW - 2 * IN_W){1'b0}}, in_mag};
  assign val_c   = in_sign ? -$signed(mag_ext) : $signed(mag_ext);

  always_comb begin
    acc_ext = mode2 ? $signed({{2{acc[ACC_W-1]}}, acc}) : $signed({2'b00, acc});
    sum     = acc_ext + val2;
    wide    = {{(SAT_MAX_W - SW){sum[SW-1]}}, sum};
    clamped = mode2 ? sat_signed(wide, ACC_W) : sat_unsigned(wide, ACC_W);
    sat_hit = (clamped != wide);
    res     = clamped[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2      <= 1'b0;
      last2   <= 1'b0;
      mode2   <= 1'b0;
      val2    <= '0;
      acc     <= '0;
      sticky  <= 1'b0;
      out_acc <= '0;
      out_sat <= 1'b0;
    end else if (flush) begin
      v2     <= 1'b0;
      acc    <= '0;
      sticky <= 1'b0;
    end else if (advance) begin
      v2    <= in_valid;
      val2  <= val_c;
      mode2 <= in_mode;
      last2 <= in_last;
      if (v2) begin
        if (last2) begin
          out_acc <= res;
          out_sat <= sticky | sat_hit;
          acc     <= '0;
          sticky  <= 1'b0;
        end else begin
          acc    <= res;
          sticky <= sticky | sat_hit;
        end
      end
    end
  end

endmodule

// File: rtl/packed_mac_pe.sv
// Packed multiply-accumulate processing element.
// One multiplier forms LANES products A*B[k] at once by packing the B
// magnitudes at 2*IN_W-bit spacing; signs are restored per lane afterwards
// and each lane keeps its own saturating accumulator.
// Pipeline: S0 magnitudes/signs, S1 packed product, S2 sign restore, then
// accumulate into the result register. valid/ready on both sides; a held
// result (out_valid && !out_ready) freezes the whole pipeline.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   signed_mode           per-beat operand format (1 = two's complement)
//   in_valid/in_ready     input beat handshake
//   in_last               beat closes the current sum
//   in_a                  shared operand A
//   in_b                  lane k operand at [k*IN_W +: IN_W]
//   flush                 drop partial sums and in-flight beats
//   out_valid/out_ready   result handshake
//   out_acc               lane k sum at [k*ACC_W +: ACC_W]
//   out_sat               lane k saturated during this sum
module packed_mac_pe
  import pe_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int LANES = 2,
  parameter int ACC_W = 2 * IN_W + 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   signed_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [IN_W-1:0]        in_a,
  input  logic [LANES*IN_W-1:0]  in_b,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_acc,
  output logic [LANES-1:0]       out_sat
);

  localparam int LS   = lane_sp(IN_W);
  localparam int PK_W = LANES * LS;

  logic stall;
  logic advance;
  logic accept;

  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = !stall && reset && !flush;
  assign accept   = in_valid && in_ready;

  // Operand magnitudes. -2^(IN_W-1) maps to 2^(IN_W-1), which still fits
  // the IN_W-bit unsigned magnitude.
  logic                  a_neg;
  logic [IN_W-1:0]       a_mag_c;
  logic [LANES*IN_W-1:0] b_mag_c;
  logic [LANES-1:0]      sign_c;

  assign a_neg   = signed_mode & in_a[IN_W-1];
  assign a_mag_c = a_neg ? -in_a : in_a;

  // S0 registers
  logic                  v0;
  logic                  last0;
  logic                  mode0;
  logic [IN_W-1:0]       a_mag0;
  logic [LANES*IN_W-1:0] b_mag0;
  logic [LANES-1:0]      sign0;

  // S1 registers
  logic                  v1;
  logic                  last1;
  logic                  mode1;
  logic [LANES-1:0]      sign1;
  logic [PK_W-1:0]       prod1;

  // S2 control mirror of the lane stage, used for out_valid
  logic                  v2;
  logic                  last2;

  logic [PK_W-1:0]       packed_b;
  logic [PK_W-1:0]       prod_c;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_in
      logic            b_neg;
      logic [IN_W-1:0] b_raw;
      assign b_raw  = in_b[gi*IN_W +: IN_W];
      assign b_neg  = signed_mode & b_raw[IN_W-1];
      assign b_mag_c[gi*IN_W +: IN_W] = b_neg ? -b_raw : b_raw;
      assign sign_c[gi] = a_neg ^ b_neg;
      assign packed_b[gi*LS +: LS] = {{(LS - IN_W){1'b0}}, b_mag0[gi*IN_W +: IN_W]};
    end
  endgenerate

  // Single wide multiply; lanes cannot overlap, and the top IN_W bits of the
  // full PROD_W product are always zero, so PK_W bits are kept.
  assign prod_c = {{(PK_W - IN_W){1'b0}}, a_mag0} * packed_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0     <= 1'b0;
      last0  <= 1'b0;
      mode0  <= 1'b0;
      a_mag0 <= '0;
      b_mag0 <= '0;
      sign0  <= '0;
      v1     <= 1'b0;
      last1  <= 1'b0;
      mode1  <= 1'b0;
      sign1  <= '0;
      prod1  <= '0;
      v2     <= 1'b0;
      last2  <= 1'b0;
    end else if (flush) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (advance) begin
      v0 <= accept;
      if (accept) begin
        last0  <= in_last;
        mode0  <= signed_mode;
        a_mag0 <= a_mag_c;
        b_mag0 <= b_mag_c;
        sign0  <= sign_c;
      end
      v1    <= v0;
      last1 <= last0;
      mode1 <= mode0;
      sign1 <= sign0;
      prod1 <= prod_c;
      v2    <= v1;
      last2 <= last1;
    end
  end

  // A new result may land in the same cycle the previous one is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
    end else if (!flush && advance && v2 && last2) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      pe_lane_acc #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
      ) u_lane (
        .clk      (clk),
        .reset    (reset),
        .advance  (advance),
        .flush    (flush),
        .in_valid (v1),
        .in_mag   (prod1[gi*LS +: LS]),
        .in_sign  (sign1[gi]),
        .in_mode  (mode1),
        .in_last  (last1),
        .out_acc  (out_acc[gi*ACC_W +: ACC_W]),
        .out_sat  (out_sat[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_packed_mac_pe.sv
// Bench for packed_mac_pe: two instances (ACC_W=24 and ACC_W=16) share all
// inputs; an integer model applies each accepted beat and queues the
// expected sums, which a monitor compares whenever a result is presented.
module tb_packed_mac_pe;

  localparam int IN_W  = 8;
  localparam int LANES = 2;
  localparam int AW    = 24;
  localparam int AW16  = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   signed_mode;
  logic                   in_valid;
  logic                   in_last;
  logic [IN_W-1:0]        in_a;
  logic [LANES*IN_W-1:0]  in_b;
  logic                   flush;
  logic                   out_ready = 1'b1;
  logic                   in_ready;
  logic                   out_valid;
  logic [LANES*AW-1:0]    out_acc;
  logic [LANES-1:0]       out_sat;
  logic                   in_ready16;
  logic                   out_valid16;
  logic [LANES*AW16-1:0]  out_acc16;
  logic [LANES-1:0]       out_sat16;

  always #5 clk = ~clk;

  packed_mac_pe #(.IN_W(IN_W), .LANES(LANES), .ACC_W(AW)) dut (
    .clk(clk), .reset(reset), .signed_mode(signed_mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_a(in_a), .in_b(in_b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_sat(out_sat)
  );

  packed_mac_pe #(.IN_W(IN_W), .LANES(LANES), .ACC_W(AW16)) dut16 (
    .clk(clk), .reset(reset), .signed_mode(signed_mode), .in_valid(in_valid),
    .in_ready(in_ready16), .in_last(in_last), .in_a(in_a), .in_b(in_b),
    .flush(flush), .out_valid(out_valid16), .out_ready(out_ready),
    .out_acc(out_acc16), .out_sat(out_sat16)
  );

  int n_vec = 0;
  int n_err = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready

  typedef struct {
    longint e[2];
    bit     s[2];
    longint f[2];
    bit     t[2];
  } exp_t;

  exp_t   exp_q[$];
  longint acc24[2];
  longint acc16[2];
  bit     sat24[2];
  bit     sat16[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic longint clamp(input longint v, input int w, input bit sgn, output bit hit);
    longint hi;
    longint lo;
    if (sgn) begin
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
    end else begin
      hi = (longint'(1) <<< w) - 1;
      lo = 0;
    end
    hit = 1'b0;
    if (v > hi) begin hit = 1'b1; return hi; end
    if (v < lo) begin hit = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      acc24[k] = 0; acc16[k] = 0; sat24[k] = 0; sat16[k] = 0;
    end
  endtask

  task automatic model_beat(input logic [7:0] a, input logic [15:0] b, input bit last, input bit mode);
    exp_t x;
    bit   h;
    for (int k = 0; k < 2; k++) begin
      logic [7:0] bk;
      longint     p;
      bk = b[k*8 +: 8];
      if (mode) p = longint'($signed(a)) * longint'($signed(bk));
      else      p = longint'(a) * longint'(bk);
      acc24[k] = clamp(acc24[k] + p, AW, mode, h);
      sat24[k] |= h;
      acc16[k] = clamp(acc16[k] + p, AW16, mode, h);
      sat16[k] |= h;
    end
    if (last) begin
      x.e = acc24; x.s = sat24; x.f = acc16; x.t = sat16;
      exp_q.push_back(x);
      model_clear();
    end
  endtask

  // Offer one beat until accepted; the model sees it at the accepting edge.
  task automatic send_beat(input logic [7:0] a, input logic [15:0] b, input bit last, input bit mode);
    signed_mode = mode; in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (in_ready) begin
        model_beat(a, b, last, mode);
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_acc", 64'(out_acc), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    model_clear();
    exp_q.delete();
    idle(2);
    reset = 1'b1;
    idle(1);
  endtask

  always @(negedge clk) begin
    out_ready = (rdy_mode == 0) ? 1'b1 :
                (rdy_mode == 1) ? ($urandom_range(0, 9) < 7) : 1'b0;
  end

  // Compare the presented result every cycle it is shown (covers stability
  // under backpressure) and retire it when it is taken.
  exp_t mon_x;
  always @(negedge clk) begin
    #2;
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        mon_x = exp_q[0];
        check("valid16", 64'(out_valid16), 64'd1);
        for (int k = 0; k < 2; k++) begin
          check($sformatf("acc24_lane%0d", k), 64'(out_acc[k*AW +: AW]),
                64'(mon_x.e[k]) & ((64'd1 << AW) - 1));
          check($sformatf("sat24_lane%0d", k), 64'(out_sat[k]), 64'(mon_x.s[k]));
          check($sformatf("acc16_lane%0d", k), 64'(out_acc16[k*AW16 +: AW16]),
                64'(mon_x.f[k]) & ((64'd1 << AW16) - 1));
          check($sformatf("sat16_lane%0d", k), 64'(out_sat16[k]), 64'(mon_x.t[k]));
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit mode;
    int len;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; signed_mode = 1'b0;
    model_clear();
    idle(2);
    check("init_in_ready", 64'(in_ready), 64'd0);
    check("init_out_valid", 64'(out_valid), 64'd0);
    check("init_out_acc", 64'(out_acc), 64'd0);
    check("init_out_sat", 64'(out_sat), 64'd0);
    reset = 1'b1;
    idle(1);

    // Single signed beat and its latency: A=-3, B={-7,5} -> {21,-15}
    send_beat(8'hFD, {8'hF9, 8'h05}, 1'b1, 1'b1);
    check("lat_t0", 64'(out_valid), 64'd0);
    idle(1); check("lat_t1", 64'(out_valid), 64'd0);
    idle(1); check("lat_t2", 64'(out_valid), 64'd0);
    idle(1); check("lat_t3", 64'(out_valid), 64'd1);
    check("t1_lane0", 64'(out_acc[23:0]), 64'h00FFFFF1);
    check("t1_lane1", 64'(out_acc[47:24]), 64'd21);
    idle(2);

    // Signed extremes: A=-128, B={127,-128} -> {-16256,16384}
    send_beat(8'h80, {8'h7F, 8'h80}, 1'b1, 1'b1);
    idle(5);

    // Four beats of A=100, B={-100,100}; the 16-bit instance saturates
    for (int i = 0; i < 4; i++) send_beat(8'd100, {8'h9C, 8'd100}, i == 3, 1'b1);
    idle(5);

    // Unsigned: A=255, B={1,255} -> {255,65025}, then back-to-back 1-beat sums
    send_beat(8'hFF, {8'h01, 8'hFF}, 1'b1, 1'b0);
    idle(5);
    for (int i = 0; i < 4; i++) send_beat(8'($urandom), 16'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_valid%0d", i), 64'(out_valid), 64'd1);
      idle(1);
    end
    idle(3);

    // Long sums that saturate the 24-bit accumulators, signed then unsigned
    for (int i = 0; i < 520; i++) send_beat(8'h80, {8'h80, 8'h7F}, i == 519, 1'b1);
    idle(5);
    for (int i = 0; i < 300; i++) send_beat(8'hFF, {8'hFF, 8'hFF}, i == 299, 1'b0);
    idle(5);

    // Backpressure: result held 5+ cycles, next beat must wait
    rdy_mode = 2;
    send_beat(8'd7, {8'hFE, 8'd9}, 1'b1, 1'b1);
    idle(4);
    fork
      send_beat(8'd11, {8'd12, 8'hF3}, 1'b1, 1'b1);
      begin
        for (int i = 0; i < 5; i++) begin
          #1;
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_out_valid", 64'(out_valid), 64'd1);
          @(negedge clk);
        end
        rdy_mode = 0;
      end
    join
    idle(6);

    // Reset mid-sum, then A=2, B={3,4} -> {6,8}
    send_beat(8'd50, {8'd60, 8'd70}, 1'b0, 1'b1);
    send_beat(8'd50, {8'd60, 8'd70}, 1'b0, 1'b1);
    do_reset();
    send_beat(8'd2, {8'd4, 8'd3}, 1'b1, 1'b1);
    idle(5);

    // Reset while a result is stalled
    rdy_mode = 2;
    send_beat(8'd5, {8'd5, 8'd5}, 1'b1, 1'b1);
    idle(4);
    do_reset();
    rdy_mode = 0;

    // Flush mid-sum, then A=2, B={3,4} -> {6,8}
    send_beat(8'd90, {8'd80, 8'd70}, 1'b0, 1'b1);
    send_beat(8'd90, {8'd80, 8'd70}, 1'b0, 1'b1);
    idle(4);
    do_flush();
    send_beat(8'd2, {8'd4, 8'd3}, 1'b1, 1'b1);
    idle(5);

    // Flush together with a valid beat: the beat is dropped
    signed_mode = 1'b1; in_a = 8'd99; in_b = {8'd99, 8'd99}; in_last = 1'b1;
    in_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    model_clear();
    idle(5);
    check("flush_drop_no_out", 64'(out_valid), 64'd0);

    // Flush while a result is stalled: the result survives
    rdy_mode = 2;
    send_beat(8'hF0, {8'd3, 8'hC0}, 1'b1, 1'b1);
    idle(4);
    do_flush();
    check("flush_keeps_valid", 64'(out_valid), 64'd1);
    rdy_mode = 0;
    idle(3);

    // Randomised sums with random backpressure and occasional flushes
    rdy_mode = 1;
    for (int s = 0; s < 60; s++) begin
      mode = 1'($urandom);
      len  = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 19) == 0) begin
          rdy_mode = 0;
          idle(5);
          do_flush();
          rdy_mode = 1;
        end
        send_beat(8'($urandom), 16'($urandom), i == len - 1, mode);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end

    rdy_mode = 0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
